// File: rtl/fft_bin_capture_if.sv
// FFT output stream bundle: one beat carries the voltage (ch0) and current
// (ch1) channel values for the same bin index.
//   src_valid : beat valid
//   src_sop   : first beat of frame (qualified by src_valid)
//   src_eop   : last beat of frame (qualified by src_valid)
//   ch0_re/im : signed voltage-channel bin value
//   ch1_re/im : signed current-channel bin value
// master = FFT output side, slave = bin capture side.
interface fft_bin_capture_if #(
    parameter int DW = 16
);
    logic                 src_valid;
    logic                 src_sop;
    logic                 src_eop;
    logic signed [DW-1:0] ch0_re;
    logic signed [DW-1:0] ch0_im;
    logic signed [DW-1:0] ch1_re;
    logic signed [DW-1:0] ch1_im;

    modport master (
        output src_valid, src_sop, src_eop, ch0_re, ch0_im, ch1_re, ch1_im
    );

    modport slave (
        input  src_valid, src_sop, src_eop, ch0_re, ch0_im, ch1_re, ch1_im
    );
endinterface

// File: rtl/fft_bin_capture.sv
// Captures the complex voltage/current values at one FFT bin, computes the
// power re^2+im^2 of each channel and pulses en_start so the controller can
// re-arm the FFT.
//   clk, rstn     : clock, asynchronous active-low reset
//   clr           : synchronous clear (controller fft_reset); aborts any frame
//   bin_addr      : bin to capture, latched at start of frame
//   src           : FFT output stream (slave side)
//   cap0_*/cap1_* : captured bin values, updated with res_valid
//   ch0/ch1_pwr   : unsigned power at the captured bin
//   res_valid     : one-cycle pulse, results updated
//   en_start      : one-cycle pulse to controller, same cycle as res_valid
//   frame_err     : one-cycle pulse on a malformed frame
module fft_bin_capture #(
    parameter int DW     = 16,
    parameter int AW     = 11,
    parameter int NPOINT = 2048
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic [AW-1:0]        bin_addr,
    fft_bin_capture_if.slave     src,
    output logic signed [DW-1:0] cap0_re,
    output logic signed [DW-1:0] cap0_im,
    output logic signed [DW-1:0] cap1_re,
    output logic signed [DW-1:0] cap1_im,
    output logic [2*DW:0]        ch0_pwr,
    output logic [2*DW:0]        ch1_pwr,
    output logic                 res_valid,
    output logic                 en_start,
    output logic                 frame_err
);
    typedef enum logic [1:0] {WAIT_SOP, COLLECT, SQ, SUM} state_t;

    // Counter is one bit wider than the bin index so NPOINT == 2**AW still fits.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(NPOINT - 1);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    state_t                 state_q, state_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic [AW-1:0]          bin_q, bin_d;
    logic                   captured_q, captured_d;
    logic signed [DW-1:0]   c0_re_q, c0_re_d, c0_im_q, c0_im_d;
    logic signed [DW-1:0]   c1_re_q, c1_re_d, c1_im_q, c1_im_d;
    logic signed [2*DW-1:0] p0_re_q, p0_re_d, p0_im_q, p0_im_d;
    logic signed [2*DW-1:0] p1_re_q, p1_re_d, p1_im_q, p1_im_d;
    logic signed [DW-1:0]   cap0_re_q, cap0_re_d, cap0_im_q, cap0_im_d;
    logic signed [DW-1:0]   cap1_re_q, cap1_re_d, cap1_im_q, cap1_im_d;
    logic [2*DW:0]          ch0_pwr_q, ch0_pwr_d, ch1_pwr_q, ch1_pwr_d;
    logic                   res_valid_q, res_valid_d;
    logic                   en_start_q, en_start_d;
    logic                   frame_err_q, frame_err_d;

    logic do_start;
    logic cap_en;
    logic hit;
    logic last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        captured_d  = captured_q;
        c0_re_d     = c0_re_q;
        c0_im_d     = c0_im_q;
        c1_re_d     = c1_re_q;
        c1_im_d     = c1_im_q;
        p0_re_d     = p0_re_q;
        p0_im_d     = p0_im_q;
        p1_re_d     = p1_re_q;
        p1_im_d     = p1_im_q;
        cap0_re_d   = cap0_re_q;
        cap0_im_d   = cap0_im_q;
        cap1_re_d   = cap1_re_q;
        cap1_im_d   = cap1_im_q;
        ch0_pwr_d   = ch0_pwr_q;
        ch1_pwr_d   = ch1_pwr_q;
        res_valid_d = 1'b0;
        en_start_d  = 1'b0;
        frame_err_d = 1'b0;
        do_start    = 1'b0;
        cap_en      = 1'b0;
        hit         = (cnt_q == {1'b0, bin_q});
        last        = (cnt_q == LAST_IDX);

        case (state_q)
            WAIT_SOP: begin
                if (src.src_valid && src.src_sop) begin
                    do_start = 1'b1;
                end
            end
            COLLECT: begin
                if (src.src_valid) begin
                    if (src.src_sop) begin
                        // Repeated sop: drop the partial frame and restart.
                        frame_err_d = 1'b1;
                        do_start    = 1'b1;
                    end else begin
                        if (hit) begin
                            cap_en     = 1'b1;
                            captured_d = 1'b1;
                        end
                        if (src.src_eop) begin
                            // hit covers a capture on the last beat itself.
                            if (last && (captured_q || hit)) begin
                                state_d = SQ;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = WAIT_SOP;
                            end
                        end else if (last) begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_SOP;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
            end
            SQ: begin
                p0_re_d = (2*DW)'(c0_re_q) * (2*DW)'(c0_re_q);
                p0_im_d = (2*DW)'(c0_im_q) * (2*DW)'(c0_im_q);
                p1_re_d = (2*DW)'(c1_re_q) * (2*DW)'(c1_re_q);
                p1_im_d = (2*DW)'(c1_im_q) * (2*DW)'(c1_im_q);
                state_d = SUM;
            end
            SUM: begin
                // Squares are non-negative, so zero extension is exact.
                ch0_pwr_d   = {1'b0, p0_re_q} + {1'b0, p0_im_q};
                ch1_pwr_d   = {1'b0, p1_re_q} + {1'b0, p1_im_q};
                cap0_re_d   = c0_re_q;
                cap0_im_d   = c0_im_q;
                cap1_re_d   = c1_re_q;
                cap1_im_d   = c1_im_q;
                res_valid_d = 1'b1;
                en_start_d  = 1'b1;
                state_d     = WAIT_SOP;
            end
            default: state_d = WAIT_SOP;
        endcase

        if (do_start) begin
            bin_d      = bin_addr;
            cnt_d      = ONE;
            cap_en     = (bin_addr == '0);
            captured_d = (bin_addr == '0);
            state_d    = COLLECT;
            if (src.src_eop) begin
                // A one-beat frame is only legal when the frame length is one.
                if (LAST_IDX == '0 && bin_addr == '0) begin
                    state_d = SQ;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_SOP;
                end
            end
        end

        if (cap_en) begin
            c0_re_d = src.ch0_re;
            c0_im_d = src.ch0_im;
            c1_re_d = src.ch1_re;
            c1_im_d = src.ch1_im;
        end

        // Clear wins over everything, including a simultaneous sop.
        if (clr) begin
            state_d     = WAIT_SOP;
            cnt_d       = '0;
            captured_d  = 1'b0;
            res_valid_d = 1'b0;
            en_start_d  = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= WAIT_SOP;
            cnt_q       <= '0;
            bin_q       <= '0;
            captured_q  <= 1'b0;
            c0_re_q     <= '0;
            c0_im_q     <= '0;
            c1_re_q     <= '0;
            c1_im_q     <= '0;
            p0_re_q     <= '0;
            p0_im_q     <= '0;
            p1_re_q     <= '0;
            p1_im_q     <= '0;
            cap0_re_q   <= '0;
            cap0_im_q   <= '0;
            cap1_re_q   <= '0;
            cap1_im_q   <= '0;
            ch0_pwr_q   <= '0;
            ch1_pwr_q   <= '0;
            res_valid_q <= 1'b0;
            en_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            captured_q  <= captured_d;
            c0_re_q     <= c0_re_d;
            c0_im_q     <= c0_im_d;
            c1_re_q     <= c1_re_d;
            c1_im_q     <= c1_im_d;
            p0_re_q     <= p0_re_d;
            p0_im_q     <= p0_im_d;
            p1_re_q     <= p1_re_d;
            p1_im_q     <= p1_im_d;
            cap0_re_q   <= cap0_re_d;
            cap0_im_q   <= cap0_im_d;
            cap1_re_q   <= cap1_re_d;
            cap1_im_q   <= cap1_im_d;
            ch0_pwr_q   <= ch0_pwr_d;
            ch1_pwr_q   <= ch1_pwr_d;
            res_valid_q <= res_valid_d;
            en_start_q  <= en_start_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cap0_re   = cap0_re_q;
    assign cap0_im   = cap0_im_q;
    assign cap1_re   = cap1_re_q;
    assign cap1_im   = cap1_im_q;
    assign ch0_pwr   = ch0_pwr_q;
    assign ch1_pwr   = ch1_pwr_q;
    assign res_valid = res_valid_q;
    assign en_start  = en_start_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_fft_bin_capture.sv
// Directed bench for fft_bin_capture: full frames with and without src_valid
// gaps, malformed frames, mid-frame bin change, clr abort and async reset.
module tb_fft_bin_capture;
    localparam int DW = 16;
    localparam int AW = 11;
    localparam int NP = 2048;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clr = 1'b0;
    logic [AW-1:0] bin_addr = '0;

    logic signed [DW-1:0] cap0_re, cap0_im, cap1_re, cap1_im;
    logic [2*DW:0] ch0_pwr, ch1_pwr;
    logic res_valid, en_start, frame_err;

    fft_bin_capture_if #(.DW(DW)) s_if ();

    fft_bin_capture #(.DW(DW), .AW(AW), .NPOINT(NP)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .bin_addr (bin_addr),
        .src      (s_if.slave),
        .cap0_re  (cap0_re),
        .cap0_im  (cap0_im),
        .cap1_re  (cap1_re),
        .cap1_im  (cap1_im),
        .ch0_pwr  (ch0_pwr),
        .ch1_pwr  (ch1_pwr),
        .res_valid(res_valid),
        .en_start (en_start),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_res = 0, n_err = 0, n_both = 0, n_en_mis = 0;
    int res_cyc = 0, eop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            n_res = n_res + 1;
            res_cyc = cyc;
        end
        if (frame_err === 1'b1) n_err = n_err + 1;
        if (res_valid === 1'b1 && frame_err === 1'b1) n_both = n_both + 1;
        if (en_start !== res_valid) n_en_mis = n_en_mis + 1;
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Beat data model; ov_idx selects the hand-written vector (3,-4),(-32768,-32768).
    function automatic logic signed [15:0] bval(input int seed, input int idx, input int comp, input int ov_idx);
        if (idx == ov_idx) begin
            case (comp)
                0: return 16'sd3;
                1: return -16'sd4;
                default: return 16'sh8000;
            endcase
        end
        return 16'(seed * 7919 + idx * 131 + comp * 4099 + (seed << 9));
    endfunction

    function automatic longint epwr(input longint re, input longint im);
        return re * re + im * im;
    endfunction

    task automatic check_result(input string tag, input int seed, input int bin, input int ov);
        longint r0, i0, r1, i1;
        r0 = bval(seed, bin, 0, ov);
        i0 = bval(seed, bin, 1, ov);
        r1 = bval(seed, bin, 2, ov);
        i1 = bval(seed, bin, 3, ov);
        check_eq({tag, "_cap0_re"}, cap0_re, r0);
        check_eq({tag, "_cap0_im"}, cap0_im, i0);
        check_eq({tag, "_cap1_re"}, cap1_re, r1);
        check_eq({tag, "_cap1_im"}, cap1_im, i1);
        check_eq({tag, "_pwr0"}, ch0_pwr, epwr(r0, i0));
        check_eq({tag, "_pwr1"}, ch1_pwr, epwr(r1, i1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a negedge; sop on beat 0, eop on beat eop_at.
    task automatic run_frame(input int seed, input int nbeats, input int eop_at, input int bin,
                             input int chg_at, input int bin_new, input int clr_at,
                             input bit gaps, input int ov_idx);
        bin_addr = AW'(bin);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                int ng;
                ng = $urandom_range(1, 3);
                for (int g = 0; g < ng; g++) begin
                    s_if.src_valid = 1'b0;
                    s_if.src_sop   = 1'($urandom_range(0, 1));
                    s_if.src_eop   = 1'($urandom_range(0, 1));
                    s_if.ch0_re    = 16'($urandom);
                    s_if.ch0_im    = 16'($urandom);
                    s_if.ch1_re    = 16'($urandom);
                    s_if.ch1_im    = 16'($urandom);
                    clr = 1'b0;
                    @(negedge clk);
                end
            end
            if (k == chg_at) bin_addr = AW'(bin_new);
            clr = (k == clr_at);
            s_if.src_valid = 1'b1;
            s_if.src_sop   = (k == 0);
            s_if.src_eop   = (k == eop_at);
            s_if.ch0_re    = bval(seed, k, 0, ov_idx);
            s_if.ch0_im    = bval(seed, k, 1, ov_idx);
            s_if.ch1_re    = bval(seed, k, 2, ov_idx);
            s_if.ch1_im    = bval(seed, k, 3, ov_idx);
            if (k == eop_at) eop_cyc = cyc;
            @(negedge clk);
        end
        clr = 1'b0;
        s_if.src_valid = 1'b0;
        s_if.src_sop   = 1'b0;
        s_if.src_eop   = 1'b0;
    endtask

    initial begin
        int r0, e0;
        s_if.src_valid = 1'b0;
        s_if.src_sop   = 1'b0;
        s_if.src_eop   = 1'b0;
        s_if.ch0_re    = '0;
        s_if.ch0_im    = '0;
        s_if.ch1_re    = '0;
        s_if.ch1_im    = '0;

        idle(3);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_en_start", en_start, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_pwr0", ch0_pwr, 0);
        check_eq("rst_cap1_im", cap1_im, 0);
        rstn = 1'b1;
        idle(2);

        // Hand-computed vector at bin 5: 3^2+4^2=25, 2*(2^15)^2=2^31.
        r0 = n_res; e0 = n_err;
        run_frame(1, NP, NP - 1, 5, -1, 0, -1, 1'b0, 5);
        idle(6);
        check_eq("t1_res_cnt", n_res - r0, 1);
        check_eq("t1_err_cnt", n_err - e0, 0);
        check_eq("t1_latency", res_cyc - eop_cyc, 3);
        check_eq("t1_pwr0", ch0_pwr, 25);
        check_eq("t1_pwr1", ch1_pwr, 64'd2147483648);
        check_eq("t1_cap0_re", cap0_re, 3);
        check_eq("t1_cap0_im", cap0_im, -4);
        check_eq("t1_cap1_re", cap1_re, -32768);
        check_eq("t1_cap1_im", cap1_im, -32768);

        // Bin 0 (sop beat) with gaps.
        r0 = n_res;
        run_frame(2, NP, NP - 1, 0, -1, 0, -1, 1'b1, -1);
        idle(6);
        check_eq("t2_res_cnt", n_res - r0, 1);
        check_eq("t2_latency", res_cyc - eop_cyc, 3);
        check_result("t2", 2, 0, -1);

        // Bin 2047 (eop beat) with gaps.
        r0 = n_res;
        run_frame(3, NP, NP - 1, NP - 1, -1, 0, -1, 1'b1, -1);
        idle(6);
        check_eq("t3_res_cnt", n_res - r0, 1);
        check_eq("t3_latency", res_cyc - eop_cyc, 3);
        check_result("t3", 3, NP - 1, -1);

        // sop again at beat 100, then a complete second frame.
        r0 = n_res; e0 = n_err;
        run_frame(4, 100, -1, 50, -1, 0, -1, 1'b0, -1);
        run_frame(5, NP, NP - 1, 50, -1, 0, -1, 1'b0, -1);
        idle(6);
        check_eq("t4_err_cnt", n_err - e0, 1);
        check_eq("t4_res_cnt", n_res - r0, 1);
        check_result("t4", 5, 50, -1);

        // Early eop at beat 1000.
        r0 = n_res; e0 = n_err;
        run_frame(6, 1001, 1000, 10, -1, 0, -1, 1'b0, -1);
        idle(6);
        check_eq("t5_err_cnt", n_err - e0, 1);
        check_eq("t5_res_cnt", n_res - r0, 0);
        check_result("t5_hold", 5, 50, -1);

        // Missing eop on beat 2047.
        r0 = n_res; e0 = n_err;
        run_frame(7, NP, -1, 10, -1, 0, -1, 1'b0, -1);
        idle(6);
        check_eq("t6_err_cnt", n_err - e0, 1);
        check_eq("t6_res_cnt", n_res - r0, 0);
        check_result("t6_hold", 5, 50, -1);

        // bin_addr changes from 2047 to 3 mid-frame; latched bin must be used.
        r0 = n_res; e0 = n_err;
        run_frame(8, NP, NP - 1, NP - 1, 10, 3, -1, 1'b0, -1);
        idle(6);
        check_eq("t7_res_cnt", n_res - r0, 1);
        check_eq("t7_err_cnt", n_err - e0, 0);
        check_result("t7", 8, NP - 1, -1);

        // clr at beat 700; the rest of that frame must be ignored.
        r0 = n_res; e0 = n_err;
        run_frame(9, NP, NP - 1, 100, -1, 0, 700, 1'b0, -1);
        idle(6);
        check_eq("t8_abort_res", n_res - r0, 0);
        check_eq("t8_abort_err", n_err - e0, 0);
        check_result("t8_hold", 8, NP - 1, -1);
        run_frame(10, NP, NP - 1, 9, -1, 0, -1, 1'b0, -1);
        idle(6);
        check_eq("t8_res_cnt", n_res - r0, 1);
        check_result("t8", 10, 9, -1);

        // Async reset while in SQ.
        r0 = n_res;
        run_frame(11, NP, NP - 1, 20, -1, 0, -1, 1'b0, -1);
        rstn = 1'b0;
        #1;
        check_eq("t9_rst_cap0_re", cap0_re, 0);
        check_eq("t9_rst_pwr0", ch0_pwr, 0);
        check_eq("t9_rst_pwr1", ch1_pwr, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(6);
        check_eq("t9_res_cnt", n_res - r0, 0);
        check_eq("t9_pwr0_after", ch0_pwr, 0);
        check_eq("t9_cap1_re_after", cap1_re, 0);

        check_eq("err_with_res", n_both, 0);
        check_eq("en_start_vs_res", n_en_mis, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
